// File: rtl/rtr_out_sched_if.sv
// ============================================================================
// Module      : rtr_out_sched_if
// Description : Request/grant/credit bundle between router inputs and the
//               per-output switch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtr_out_sched_if #(
    parameter int IN_PORTS = 4,
    parameter int CREDITS  = 4
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic [IN_PORTS-1:0] req;
    logic [IN_PORTS-1:0] req_head;
    logic [IN_PORTS-1:0] req_tail;
    logic                credit_in;
    logic [IN_PORTS-1:0] grant;
    logic                valid_out;
    logic                outp_avail;
    logic [CNT_W-1:0]    credits;
    logic                wd_err;

    modport master (
        output req, req_head, req_tail, credit_in,
        input  grant, valid_out, outp_avail, credits, wd_err
    );

    modport slave (
        input  req, req_head, req_tail, credit_in,
        output grant, valid_out, outp_avail, credits, wd_err
    );
endinterface

`default_nettype wire

// File: rtl/rtr_out_sched.sv
// ============================================================================
// Module      : rtr_out_sched
// Description : Round-robin, packet-locking, credit-gated output scheduler.
//               Optional watchdog: define RTR_OUT_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtr_out_sched #(
    parameter int IN_PORTS  = 4,
    parameter int CREDITS   = 4,
    parameter int WD_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst,
    rtr_out_sched_if.slave bus
);
    localparam int PTR_W = $clog2(IN_PORTS);
    localparam int CNT_W = $clog2(CREDITS + 1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    localparam logic [CNT_W-1:0] C_CRED_MAX = CNT_W'(CREDITS);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(IN_PORTS - 1);

    logic [0:0]       state_q,   state_d;
    logic [PTR_W-1:0] ptr_q,     ptr_d;
    logic [PTR_W-1:0] owner_q,   owner_d;
    logic [CNT_W-1:0] credits_q, credits_d;

    logic [PTR_W-1:0] winner;
    logic             found;
    logic             fire;
    int               idx;

    // Arbitration: the lock owner alone when LOCKED, otherwise the first
    // head-flit requester at or after the round-robin pointer.
    always_comb begin
        winner = owner_q;
        found  = 1'b0;
        idx    = 0;
        if (state_q == S_LOCKED) begin
            found = bus.req[owner_q];
        end else begin
            for (int k = 0; k < IN_PORTS; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= IN_PORTS) idx = idx - IN_PORTS;
                if (!found && bus.req[PTR_W'(idx)] && bus.req_head[PTR_W'(idx)]) begin
                    found  = 1'b1;
                    winner = PTR_W'(idx);
                end
            end
        end
    end

    assign fire = found && (credits_q != '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            credits_q <= C_CRED_MAX;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        credits_d = credits_q;
        if (fire) begin
            case (state_q)
                S_IDLE: begin
                    ptr_d = (winner == C_PTR_LAST) ? '0 : winner + PTR_W'(1);
                    if (!bus.req_tail[winner]) begin
                        state_d = S_LOCKED;
                        owner_d = winner;
                    end
                end
                S_LOCKED: begin
                    if (bus.req_tail[owner_q]) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Returned credits beyond the buffer depth are dropped.
        if (fire && !bus.credit_in) begin
            credits_d = credits_q - CNT_W'(1);
        end else if (!fire && bus.credit_in && (credits_q != C_CRED_MAX)) begin
            credits_d = credits_q + CNT_W'(1);
        end
    end

    // Output logic
    always_comb begin
        bus.grant      = fire ? (IN_PORTS'(1) << winner) : '0;
        bus.valid_out  = fire;
        bus.outp_avail = (state_q == S_IDLE);
        bus.credits    = credits_q;
    end

`ifdef RTR_OUT_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] C_WD_MAX = WD_W'(WD_CYCLES);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q;
    logic            wd_stall;

    assign wd_stall = (state_q == S_LOCKED) && (!bus.req[owner_q] || (credits_q == '0));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (fire || (state_q == S_IDLE)) begin
            wd_cnt_d = '0;
        end else if (wd_stall && (wd_cnt_q != C_WD_MAX)) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_cnt_d == C_WD_MAX) wd_err_q <= 1'b1;
        end
    end

    assign bus.wd_err = wd_err_q;
`else
    logic w_unused_wd;
    assign w_unused_wd = (WD_CYCLES != 0);
    assign bus.wd_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rtr_out_sched.sv
// ============================================================================
// Module      : tb_rtr_out_sched
// Description : Directed vector bench for rtr_out_sched (CREDITS=4 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtr_out_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rtr_out_sched_if #(.IN_PORTS(4), .CREDITS(4)) bus4 ();
    rtr_out_sched_if #(.IN_PORTS(4), .CREDITS(2)) bus2 ();

    rtr_out_sched #(.IN_PORTS(4), .CREDITS(4), .WD_CYCLES(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    rtr_out_sched #(.IN_PORTS(4), .CREDITS(2), .WD_CYCLES(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] head;
        logic [3:0] tail;
        logic       ci;
        logic [3:0] e_grant;
        logic       e_valid;
        logic       e_avail;
        logic [2:0] e_cred;
    } vec_t;

    vec_t vt[21];

    function automatic vec_t mk(input logic [3:0] r, h, t, input logic c,
                                input logic [3:0] g, input logic v, a,
                                input logic [2:0] cr);
        vec_t x;
        x.req = r; x.head = h; x.tail = t; x.ci = c;
        x.e_grant = g; x.e_valid = v; x.e_avail = a; x.e_cred = cr;
        return x;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive4(input logic [3:0] r, h, t, input logic c);
        @(posedge clk);
        #1;
        bus4.req = r; bus4.req_head = h; bus4.req_tail = t; bus4.credit_in = c;
        @(negedge clk);
    endtask

    task automatic drive2(input logic [3:0] r, h, t, input logic c);
        @(posedge clk);
        #1;
        bus2.req = r; bus2.req_head = h; bus2.req_tail = t; bus2.credit_in = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic exp_wd;

    initial begin
`ifdef RTR_OUT_SCHED_WATCHDOG_EN
        exp_wd = 1'b1;
`else
        exp_wd = 1'b0;
`endif
        bus4.req = '0; bus4.req_head = '0; bus4.req_tail = '0; bus4.credit_in = 1'b0;
        bus2.req = '0; bus2.req_head = '0; bus2.req_tail = '0; bus2.credit_in = 1'b0;

        //            req    head   tail   ci    grant  v     avail cred
        vt[0]  = mk(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd4);
        vt[1]  = mk(4'h5, 4'h5, 4'h5, 1'b1, 4'h1, 1'b1, 1'b1, 3'd4);
        vt[2]  = mk(4'h5, 4'h5, 4'h5, 1'b1, 4'h4, 1'b1, 1'b1, 3'd4);
        vt[3]  = mk(4'h5, 4'h5, 4'h5, 1'b1, 4'h1, 1'b1, 1'b1, 3'd4);
        vt[4]  = mk(4'h2, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 1'b1, 3'd4);
        vt[5]  = mk(4'hA, 4'h8, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 3'd4);
        vt[6]  = mk(4'hA, 4'h8, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0, 3'd4);
        vt[7]  = mk(4'h8, 4'h8, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1, 3'd4);
        vt[8]  = mk(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 3'd4);
        vt[9]  = mk(4'h6, 4'h0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 3'd4);
        vt[10] = mk(4'hE, 4'hE, 4'hE, 1'b1, 4'h2, 1'b1, 1'b1, 3'd4);
        vt[11] = mk(4'hB, 4'hB, 4'hB, 1'b1, 4'h8, 1'b1, 1'b1, 3'd4);
        vt[12] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 3'd4);
        vt[13] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 3'd3);
        vt[14] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 3'd2);
        vt[15] = mk(4'h1, 4'h1, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 3'd1);
        vt[16] = mk(4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 3'd1);
        vt[17] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 3'd1);
        vt[18] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 3'd0);
        vt[19] = mk(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 3'd0);
        vt[20] = mk(4'h1, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 3'd1);

        repeat (2) @(negedge clk);
        rst = 1'b1;

        chk("reset wd_err", 32'(bus4.wd_err), 32'd0);
        for (int i = 0; i < 21; i++) begin
            drive4(vt[i].req, vt[i].head, vt[i].tail, vt[i].ci);
            chk($sformatf("v%0d grant", i),   32'(bus4.grant),      32'(vt[i].e_grant));
            chk($sformatf("v%0d valid", i),   32'(bus4.valid_out),  32'(vt[i].e_valid));
            chk($sformatf("v%0d avail", i),   32'(bus4.outp_avail), 32'(vt[i].e_avail));
            chk($sformatf("v%0d credits", i), 32'(bus4.credits),    32'(vt[i].e_cred));
        end
        drive4(4'h0, 4'h0, 4'h0, 1'b0);

        // CREDITS=2: 4-flit packet without returned credits.
        drive2(4'h1, 4'h1, 4'h0, 1'b0);
        chk("c2 head grant", 32'(bus2.grant), 32'h1);
        chk("c2 head cred", 32'(bus2.credits), 32'd2);
        drive2(4'h1, 4'h0, 4'h0, 1'b0);
        chk("c2 body1 grant", 32'(bus2.grant), 32'h1);
        chk("c2 body1 cred", 32'(bus2.credits), 32'd1);
        drive2(4'h1, 4'h0, 4'h0, 1'b0);
        chk("c2 starve grant", 32'(bus2.grant), 32'h0);
        chk("c2 starve valid", 32'(bus2.valid_out), 32'd0);
        chk("c2 starve avail", 32'(bus2.outp_avail), 32'd0);
        chk("c2 starve cred", 32'(bus2.credits), 32'd0);
        drive2(4'h1, 4'h0, 4'h0, 1'b1);
        chk("c2 return grant", 32'(bus2.grant), 32'h0);
        drive2(4'h1, 4'h0, 4'h0, 1'b0);
        chk("c2 reuse grant", 32'(bus2.grant), 32'h1);
        chk("c2 reuse cred", 32'(bus2.credits), 32'd1);
        drive2(4'h1, 4'h0, 4'h1, 1'b0);
        chk("c2 tail starve", 32'(bus2.grant), 32'h0);
        drive2(4'h1, 4'h0, 4'h1, 1'b1);
        chk("c2 tail wait", 32'(bus2.grant), 32'h0);
        drive2(4'h1, 4'h0, 4'h1, 1'b0);
        chk("c2 tail grant", 32'(bus2.grant), 32'h1);
        drive2(4'h0, 4'h0, 4'h0, 1'b0);
        chk("c2 end avail", 32'(bus2.outp_avail), 32'd1);
        chk("c2 end cred", 32'(bus2.credits), 32'd0);

        // Asynchronous reset in the middle of a locked packet.
        do_reset();
        drive4(4'h4, 4'h4, 4'h0, 1'b0);
        chk("mr head grant", 32'(bus4.grant), 32'h4);
        drive4(4'h4, 4'h0, 4'h0, 1'b0);
        chk("mr body grant", 32'(bus4.grant), 32'h4);
        chk("mr locked avail", 32'(bus4.outp_avail), 32'd0);
        chk("mr locked cred", 32'(bus4.credits), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mr async avail", 32'(bus4.outp_avail), 32'd1);
        chk("mr async cred", 32'(bus4.credits), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        drive4(4'h4, 4'h0, 4'h4, 1'b0);
        chk("mr orphan tail", 32'(bus4.grant), 32'h0);
        chk("mr orphan avail", 32'(bus4.outp_avail), 32'd1);

        // Watchdog: owner drops its request while holding the lock.
        drive4(4'h2, 4'h2, 4'h0, 1'b0);
        chk("wd head grant", 32'(bus4.grant), 32'h2);
        for (int s = 1; s <= 16; s++) begin
            drive4(4'h0, 4'h0, 4'h0, 1'b0);
            if (s == 8) chk("wd early", 32'(bus4.wd_err), 32'd0);
        end
        drive4(4'h0, 4'h0, 4'h0, 1'b0);
        drive4(4'h0, 4'h0, 4'h0, 1'b0);
        chk("wd err", 32'(bus4.wd_err), 32'(exp_wd));
        chk("wd still locked", 32'(bus4.outp_avail), 32'd0);
        drive4(4'h2, 4'h0, 4'h2, 1'b0);
        chk("wd tail grant", 32'(bus4.grant), 32'h2);
        chk("wd cred", 32'(bus4.credits), 32'd3);
        drive4(4'h0, 4'h0, 4'h0, 1'b0);
        chk("wd held", 32'(bus4.wd_err), 32'(exp_wd));
        chk("wd idle avail", 32'(bus4.outp_avail), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/rtr_out_sched.md
# rtr_out_sched

Per-output switch scheduler for the NoC router. It shares one router output port between IN_PORTS requesting inputs using round-robin arbitration. It holds the port for the whole of a multi-flit packet and gates every grant on downstream buffer credits. Its one-hot grant vector drives the output and_or_multiplexer select, and valid_out marks each forwarded flit.

## Interface
- IN_PORTS, 4, number of requesting inputs (≥2)
- CREDITS, 4, downstream buffer depth in flits (≥1); CNT_W = $clog2(CREDITS+1)
- WD_CYCLES, 16, watchdog limit in cycles (used only with the watchdog macro)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- req  in  IN_PORTS  per-input flit-pending request
- req_head  in  IN_PORTS  flit at input i is a head (head+tail = single flit)
- req_tail  in  IN_PORTS  flit at input i is a tail
- credit_in  in  1  one downstream slot freed this cycle
- grant  out  IN_PORTS  one-hot grant, combinational, mux select
- valid_out  out  1  = |grant
- outp_avail  out  1  state == IDLE
- credits  out  CNT_W  current credit count (registered)
- wd_err  out  1  sticky watchdog error

## Operation
- States:
  - IDLE: port free.
  - LOCKED: a packet is in progress; `owner` (log2 IN_PORTS bits) is registered.
- Eligible input in IDLE: req[i] & req_head[i].
  - Body or tail flits requesting in IDLE are never granted (protocol violation, ignored).
- Eligible input in LOCKED: only `owner`, with req[owner]=1. Head flits from other inputs wait.
- Credit gate: no grant when credits == 0. grant = 0 and valid_out = 0 regardless of requests.
- IDLE arbitration: round-robin pointer `ptr`. First eligible input scanning ptr, ptr+1, …, IN_PORTS-1, 0, … wins.
- Transitions:
  - IDLE, granted single flit (head & tail) → stays IDLE.
  - IDLE, granted head without tail → LOCKED, owner = winner.
  - LOCKED, granted flit with req_tail[owner] → IDLE.
  - LOCKED, otherwise → stays LOCKED.
- Pointer update: only on a grant issued in IDLE; ptr ← (winner+1) mod IN_PORTS. LOCKED grants never move ptr.
- Credit counter, next-state rules:
  - valid_out & !credit_in → credits−1.
  - credit_in & !valid_out → credits+1, saturating at CREDITS (excess credits dropped).
  - Both set, or neither → unchanged.

## Timing
- Reset (rst=0, async): state IDLE, ptr 0, owner 0, credits CREDITS, wd_err 0.
  - Therefore outp_avail 1; grant and valid_out 0 while no requests.
- Grant latency: 0 cycles. grant/valid_out depend combinationally on req, req_head, req_tail and registered state/credits.
- State, ptr, owner, credits and outp_avail update on the rising edge after the grant.
  - outp_avail falls the cycle after a head-only grant.
  - outp_avail rises the cycle after the tail grant.
- Back-to-back: a new head can be granted the cycle after a tail or single grant.
- A credit returned in cycle t is usable for a grant in cycle t+1.
- Reset mid-packet aborts the lock immediately. The packet remainder is then treated as non-head and ignored.

## Configuration
- RTR_OUT_SCHED_WATCHDOG_EN defined:
  - A counter runs while state == LOCKED and (req[owner]==0 or credits==0).
  - It clears on any grant and on entering IDLE.
  - When it reaches WD_CYCLES, wd_err sets and stays set until reset. Scheduling behaviour is unaffected.
- Macro undefined: no counter logic; wd_err tied to 0.

## Test plan
- Reset release, req=4'b0000 → grant 0, outp_avail 1, credits 4.
- Inputs 0 and 2 send single flits each cycle, credit_in=1 each cycle → grants alternate 0001, 0100, 0001; credits stay 4; outp_avail stays 1.
- Input 1 sends head, body, tail; input 3 raises a head during the body → grants 0010 ×3; input 3 is granted the cycle after the tail; outp_avail is 0 for exactly 2 cycles.
- CREDITS=2, input 0 streams a 4-flit packet with no credit_in → 2 grants, then grant 0 while credits 0; one credit_in → exactly one more grant in the next cycle.
- credit_in=1 with credits already at 4 → credits stays 4; simultaneous grant + credit_in at credits 1 → credits stays 1.
- With RTR_OUT_SCHED_WATCHDOG_EN, WD_CYCLES=16: head granted, then owner req=0 for 16 cycles → wd_err=1 and held. Without the macro, the same stimulus → wd_err=0.
